alu_issue_stage: RTL and testbench

Decode-to-execute pipeline register that produces the ALU operand interface (op0, op1, alu_op) for the execute-stage ALU. It selects operands from register-file read data, from the 6-bit immediate, or from EX/WB forwarding. It holds state under execute stall, inserts bubbles on flush, and keeps held operands coherent with retiring writes. One instance sits between decode and execute in the pipelined core.

---
 rtl/alu_issue_stage_if.sv | 31 +++
 rtl/alu_issue_stage.sv | 145 ++++++++++++++
 tb/tb_alu_issue_stage.sv | 214 +++++++++++++++++++++
 3 files changed

// File: rtl/alu_issue_stage_if.sv
// ============================================================================
// Module  : nand_cpu_pkg / alu_input_ifc
// Brief   : ALU operation encoding and the registered operand interface
//           feeding the execute-stage ALU.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package nand_cpu_pkg;
    typedef enum logic [1:0] {
        ALU_CL   = 2'd0,
        ALU_NAND = 2'd1,
        ALU_LI   = 2'd2,
        ALU_CP   = 2'd3
    } alu_op_e;
endpackage

interface alu_input_ifc
    import nand_cpu_pkg::*;
#(
    parameter int DATA_W = 16
);
    logic [DATA_W-1:0] op0;
    logic [DATA_W-1:0] op1;
    alu_op_e           alu_op;

    modport out (output op0, output op1, output alu_op);
    modport in  (input  op0, input  op1, input  alu_op);
endinterface

`default_nettype wire

// File: rtl/alu_issue_stage.sv
// ============================================================================
// Module  : alu_issue_stage
// Brief   : Decode-to-execute register producing ALU operands with EX/WB
//           forwarding, stall hold with WB refresh, and flush bubbles.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module alu_issue_stage
    import nand_cpu_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int REG_AW = 4,
    parameter int IMM_W  = 6
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              dec_valid,
    output logic              dec_ready,
    input  alu_op_e           dec_alu_op,
    input  logic [REG_AW-1:0] dec_rs,
    input  logic [REG_AW-1:0] dec_rt,
    input  logic              dec_use_imm,
    input  logic [IMM_W-1:0]  dec_imm,
    input  logic [DATA_W-1:0] rf_rs_data,
    input  logic [DATA_W-1:0] rf_rt_data,
    input  logic              ex_fwd_en,
    input  logic [REG_AW-1:0] ex_fwd_addr,
    input  logic [DATA_W-1:0] ex_fwd_data,
    input  logic              wb_fwd_en,
    input  logic [REG_AW-1:0] wb_fwd_addr,
    input  logic [DATA_W-1:0] wb_fwd_data,
    input  logic              ex_stall,
    input  logic              flush,
    alu_input_ifc.out         alu,
    output logic              ex_valid,
    output logic [REG_AW-1:0] ex_rs_q,
    output logic [REG_AW-1:0] ex_rt_q,
    output logic              ex_use_imm_q,
    output logic [15:0]       issue_count
);

    logic              valid_q,   valid_d;
    alu_op_e           op_q,      op_d;
    logic [DATA_W-1:0] op0_q,     op0_d;
    logic [DATA_W-1:0] op1_q,     op1_d;
    logic [REG_AW-1:0] rs_q,      rs_d;
    logic [REG_AW-1:0] rt_q,      rt_d;
    logic              use_imm_q, use_imm_d;
    logic [15:0]       count_q,   count_d;

    logic              w_load;
    logic [DATA_W-1:0] w_rs_val;
    logic [DATA_W-1:0] w_rt_val;
    logic [DATA_W-1:0] w_imm_ext;
    logic              w_imm_sel;

    assign dec_ready = !rst && (!valid_q || !ex_stall);
    assign w_load    = dec_valid && dec_ready;
    assign w_imm_ext = {{(DATA_W-IMM_W){1'b0}}, dec_imm};
    assign w_imm_sel = dec_use_imm || (dec_alu_op == ALU_LI);

    // Forwarding priority: EX result is newer than the retiring WB write.
    always_comb begin
        w_rs_val = rf_rs_data;
        if (ex_fwd_en && ex_fwd_addr == dec_rs)
            w_rs_val = ex_fwd_data;
        else if (wb_fwd_en && wb_fwd_addr == dec_rs)
            w_rs_val = wb_fwd_data;

        w_rt_val = rf_rt_data;
        if (ex_fwd_en && ex_fwd_addr == dec_rt)
            w_rt_val = ex_fwd_data;
        else if (wb_fwd_en && wb_fwd_addr == dec_rt)
            w_rt_val = wb_fwd_data;
    end

    always_comb begin
        valid_d   = valid_q;
        op_d      = op_q;
        op0_d     = op0_q;
        op1_d     = op1_q;
        rs_d      = rs_q;
        rt_d      = rt_q;
        use_imm_d = use_imm_q;
        count_d   = count_q;

        if (flush) begin
            valid_d = 1'b0;
            op_d    = ALU_CL;
        end else if (w_load) begin
            valid_d   = 1'b1;
            op_d      = dec_alu_op;
            op0_d     = w_rs_val;
            op1_d     = w_imm_sel ? w_imm_ext : w_rt_val;
            rs_d      = dec_rs;
            rt_d      = dec_rt;
            use_imm_d = dec_use_imm;
            count_d   = count_q + 16'd1;
        end else if (valid_q && ex_stall) begin
            // Held operands track retiring writes; EX is frozen so only WB applies.
            if (wb_fwd_en && wb_fwd_addr == rs_q)
                op0_d = wb_fwd_data;
            if (!use_imm_q && wb_fwd_en && wb_fwd_addr == rt_q)
                op1_d = wb_fwd_data;
        end else begin
            valid_d = 1'b0;
            op_d    = ALU_CL;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q   <= 1'b0;
            op_q      <= ALU_CL;
            op0_q     <= '0;
            op1_q     <= '0;
            rs_q      <= '0;
            rt_q      <= '0;
            use_imm_q <= 1'b0;
            count_q   <= 16'd0;
        end else begin
            valid_q   <= valid_d;
            op_q      <= op_d;
            op0_q     <= op0_d;
            op1_q     <= op1_d;
            rs_q      <= rs_d;
            rt_q      <= rt_d;
            use_imm_q <= use_imm_d;
            count_q   <= count_d;
        end
    end

    assign alu.op0      = op0_q;
    assign alu.op1      = op1_q;
    assign alu.alu_op   = op_q;
    assign ex_valid     = valid_q;
    assign ex_rs_q      = rs_q;
    assign ex_rt_q      = rt_q;
    assign ex_use_imm_q = use_imm_q;
    assign issue_count  = count_q;

endmodule

`default_nettype wire

// File: tb/tb_alu_issue_stage.sv
// ============================================================================
// Module  : tb_alu_issue_stage
// Brief   : Directed self-checking bench for alu_issue_stage.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_alu_issue_stage;
    import nand_cpu_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        dec_valid;
    logic        dec_ready;
    alu_op_e     dec_alu_op;
    logic [3:0]  dec_rs;
    logic [3:0]  dec_rt;
    logic        dec_use_imm;
    logic [5:0]  dec_imm;
    logic [15:0] rf_rs_data;
    logic [15:0] rf_rt_data;
    logic        ex_fwd_en;
    logic [3:0]  ex_fwd_addr;
    logic [15:0] ex_fwd_data;
    logic        wb_fwd_en;
    logic [3:0]  wb_fwd_addr;
    logic [15:0] wb_fwd_data;
    logic        ex_stall;
    logic        flush;
    logic        ex_valid;
    logic [3:0]  ex_rs_q;
    logic [3:0]  ex_rt_q;
    logic        ex_use_imm_q;
    logic [15:0] issue_count;

    int total = 0;
    int bad   = 0;

    alu_input_ifc #(.DATA_W(16)) alu_if ();

    alu_issue_stage #(.DATA_W(16), .REG_AW(4), .IMM_W(6)) dut (
        .clk          (clk),
        .rst          (rst),
        .dec_valid    (dec_valid),
        .dec_ready    (dec_ready),
        .dec_alu_op   (dec_alu_op),
        .dec_rs       (dec_rs),
        .dec_rt       (dec_rt),
        .dec_use_imm  (dec_use_imm),
        .dec_imm      (dec_imm),
        .rf_rs_data   (rf_rs_data),
        .rf_rt_data   (rf_rt_data),
        .ex_fwd_en    (ex_fwd_en),
        .ex_fwd_addr  (ex_fwd_addr),
        .ex_fwd_data  (ex_fwd_data),
        .wb_fwd_en    (wb_fwd_en),
        .wb_fwd_addr  (wb_fwd_addr),
        .wb_fwd_data  (wb_fwd_data),
        .ex_stall     (ex_stall),
        .flush        (flush),
        .alu          (alu_if),
        .ex_valid     (ex_valid),
        .ex_rs_q      (ex_rs_q),
        .ex_rt_q      (ex_rt_q),
        .ex_use_imm_q (ex_use_imm_q),
        .issue_count  (issue_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input alu_op_e op, input logic [3:0] rs, input logic [3:0] rt,
                         input logic use_imm, input logic [5:0] imm,
                         input logic [15:0] rsd, input logic [15:0] rtd);
        dec_valid   = 1'b1;
        dec_alu_op  = op;
        dec_rs      = rs;
        dec_rt      = rt;
        dec_use_imm = use_imm;
        dec_imm     = imm;
        rf_rs_data  = rsd;
        rf_rt_data  = rtd;
    endtask

    initial begin
        rst = 1'b1; dec_valid = 1'b0; dec_alu_op = ALU_CL; dec_rs = '0; dec_rt = '0;
        dec_use_imm = 1'b0; dec_imm = '0; rf_rs_data = '0; rf_rt_data = '0;
        ex_fwd_en = 1'b0; ex_fwd_addr = '0; ex_fwd_data = '0;
        wb_fwd_en = 1'b0; wb_fwd_addr = '0; wb_fwd_data = '0;
        ex_stall = 1'b0; flush = 1'b0;

        // Reset
        step(); step();
        chk("rst_valid", 32'(ex_valid), 32'd0);
        chk("rst_op", 32'(alu_if.alu_op), 32'(ALU_CL));
        chk("rst_op0", 32'(alu_if.op0), 32'h0);
        chk("rst_op1", 32'(alu_if.op1), 32'h0);
        chk("rst_cnt", 32'(issue_count), 32'd0);
        chk("rst_ready", 32'(dec_ready), 32'd0);
        rst = 1'b0;
        #1;
        chk("post_rst_ready", 32'(dec_ready), 32'd1);

        // Plain NAND issue
        issue(ALU_NAND, 4'd2, 4'd3, 1'b0, 6'd0, 16'h00FF, 16'h0F0F);
        step();
        chk("nand_op0", 32'(alu_if.op0), 32'h00FF);
        chk("nand_op1", 32'(alu_if.op1), 32'h0F0F);
        chk("nand_op", 32'(alu_if.alu_op), 32'(ALU_NAND));
        chk("nand_valid", 32'(ex_valid), 32'd1);
        chk("nand_cnt", 32'(issue_count), 32'd1);
        chk("nand_rs", 32'(ex_rs_q), 32'd2);
        chk("nand_rt", 32'(ex_rt_q), 32'd3);

        // Forwarding priority EX > WB > RF
        issue(ALU_NAND, 4'd5, 4'd0, 1'b1, 6'h15, 16'h1111, 16'h0000);
        wb_fwd_en = 1'b1; wb_fwd_addr = 4'd5; wb_fwd_data = 16'h2222;
        ex_fwd_en = 1'b1; ex_fwd_addr = 4'd5; ex_fwd_data = 16'h3333;
        step();
        chk("fwd_ex_op0", 32'(alu_if.op0), 32'h3333);
        chk("fwd_imm_op1", 32'(alu_if.op1), 32'h0015);
        ex_fwd_en = 1'b0;
        step();
        chk("fwd_wb_op0", 32'(alu_if.op0), 32'h2222);
        chk("fwd_cnt", 32'(issue_count), 32'd3);
        wb_fwd_en = 1'b0;

        // LI ignores use_imm=0 and rt
        issue(ALU_LI, 4'd4, 4'd7, 1'b0, 6'b10_0111, 16'hABCD, 16'h5555);
        step();
        chk("li_op0", 32'(alu_if.op0), 32'hABCD);
        chk("li_op1", 32'(alu_if.op1), 32'h0027);
        chk("li_op", 32'(alu_if.alu_op), 32'(ALU_LI));

        // Stall and refresh
        issue(ALU_CP, 4'd1, 4'd6, 1'b0, 6'd0, 16'h0001, 16'h0606);
        step();
        chk("cp_op0", 32'(alu_if.op0), 32'h0001);
        chk("cp_cnt", 32'(issue_count), 32'd5);
        ex_stall = 1'b1;
        issue(ALU_NAND, 4'd9, 4'd9, 1'b0, 6'd0, 16'h7777, 16'h7777);
        #1;
        chk("stall_ready", 32'(dec_ready), 32'd0);
        step();
        chk("stall1_op0", 32'(alu_if.op0), 32'h0001);
        chk("stall1_op1", 32'(alu_if.op1), 32'h0606);
        chk("stall1_op", 32'(alu_if.alu_op), 32'(ALU_CP));
        wb_fwd_en = 1'b1; wb_fwd_addr = 4'd1; wb_fwd_data = 16'hBEEF;
        ex_fwd_en = 1'b1; ex_fwd_addr = 4'd1; ex_fwd_data = 16'hDEAD;
        #1;
        chk("stall2_ready", 32'(dec_ready), 32'd0);
        step();
        chk("refresh_op0", 32'(alu_if.op0), 32'hBEEF);
        ex_fwd_en = 1'b0;
        wb_fwd_addr = 4'd6; wb_fwd_data = 16'h1234;
        step();
        chk("refresh_op1", 32'(alu_if.op1), 32'h1234);
        chk("stall3_op0", 32'(alu_if.op0), 32'hBEEF);
        chk("stall3_valid", 32'(ex_valid), 32'd1);
        chk("stall3_cnt", 32'(issue_count), 32'd5);
        wb_fwd_en = 1'b0;
        ex_stall = 1'b0; dec_valid = 1'b0;
        step();
        chk("bubble_valid", 32'(ex_valid), 32'd0);
        chk("bubble_op", 32'(alu_if.alu_op), 32'(ALU_CL));
        chk("bubble_op0", 32'(alu_if.op0), 32'hBEEF);

        // Flush drops held and incoming instruction
        issue(ALU_NAND, 4'd2, 4'd3, 1'b0, 6'd0, 16'hAAAA, 16'h5555);
        step();
        chk("pre_flush_cnt", 32'(issue_count), 32'd6);
        issue(ALU_CP, 4'd8, 4'd8, 1'b0, 6'd0, 16'h4242, 16'h4242);
        flush = 1'b1;
        #1;
        chk("flush_ready", 32'(dec_ready), 32'd1);
        step();
        chk("flush_valid", 32'(ex_valid), 32'd0);
        chk("flush_op", 32'(alu_if.alu_op), 32'(ALU_CL));
        chk("flush_cnt", 32'(issue_count), 32'd6);
        chk("flush_op0", 32'(alu_if.op0), 32'hAAAA);
        flush = 1'b0;

        // Reset mid-hold
        issue(ALU_NAND, 4'd3, 4'd4, 1'b0, 6'd0, 16'h1357, 16'h2468);
        step();
        ex_stall = 1'b1; dec_valid = 1'b0;
        step();
        rst = 1'b1;
        step();
        chk("midrst_valid", 32'(ex_valid), 32'd0);
        chk("midrst_op0", 32'(alu_if.op0), 32'h0);
        chk("midrst_cnt", 32'(issue_count), 32'd0);
        rst = 1'b0; ex_stall = 1'b0;
        step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
